// File: rtl/uart_packet_rx.sv
// Frame parser behind uart_rx: turns a stream of byte strobes into checked command packets.
//   Frame format: SYNC, OPCODE, LEN, LEN payload bytes, CHK = (OPCODE+LEN+payload) mod 256.
//   Latency: the CHK byte strobe sampled at edge N raises o_pkt_valid right after edge N.
//   Backpressure: a held packet waits for i_pkt_ready; bytes that arrive meanwhile are dropped and flagged.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_byte_valid, i_byte           one-cycle byte strobe and data from uart_rx
//   o_pkt_valid, i_pkt_ready       packet handshake
//   o_pkt_opcode/len/payload       packet fields (payload byte k at [8k+7:8k], unused bytes 0)
//   o_chk_err/len_err/timeout/     one-cycle error pulses
//   o_overrun
//   o_busy                         a frame is in progress or a packet is held
module uart_packet_rx #(
  parameter int unsigned MAX_PAYLOAD    = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_byte_valid,
  input  logic [7:0]                         i_byte,
  output logic                               o_pkt_valid,
  input  logic                               i_pkt_ready,
  output logic [7:0]                         o_pkt_opcode,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0]   o_pkt_len,
  output logic [8*MAX_PAYLOAD-1:0]           o_pkt_payload,
  output logic                               o_chk_err,
  output logic                               o_len_err,
  output logic                               o_timeout,
  output logic                               o_overrun,
  output logic                               o_busy
);

  localparam int unsigned LW = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_OPC  = 3'd1,
    S_LEN  = 3'd2,
    S_PAY  = 3'd3,
    S_CHK  = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               opcode_q, opcode_d;
  logic [LW-1:0]            len_q, len_d;
  logic [8*MAX_PAYLOAD-1:0] payload_q, payload_d;
  logic [7:0]               acc_q, acc_d;
  logic [LW-1:0]            idx_q, idx_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic                     pkt_valid_q, pkt_valid_d;
  logic                     chk_err_q, chk_err_d;
  logic                     len_err_q, len_err_d;
  logic                     timeout_q, timeout_d;
  logic                     overrun_q, overrun_d;
  logic                     hunt_in;
  logic                     in_frame;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_HUNT;
      opcode_q    <= '0;
      len_q       <= '0;
      payload_q   <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      pkt_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      len_q       <= len_d;
      payload_q   <= payload_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      pkt_valid_q <= pkt_valid_d;
      chk_err_q   <= chk_err_d;
      len_err_q   <= len_err_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  assign in_frame = (state_q == S_OPC) || (state_q == S_LEN) ||
                    (state_q == S_PAY) || (state_q == S_CHK);

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    len_d       = len_q;
    payload_d   = payload_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    pkt_valid_d = pkt_valid_q;
    chk_err_d   = 1'b0;
    len_err_d   = 1'b0;
    timeout_d   = 1'b0;
    overrun_d   = 1'b0;
    hunt_in     = 1'b0;

    unique case (state_q)
      S_HUNT: hunt_in = 1'b1;
      S_OPC: begin
        if (i_byte_valid) begin
          opcode_d = i_byte;
          acc_d    = i_byte;
          state_d  = S_LEN;
        end
      end
      S_LEN: begin
        if (i_byte_valid) begin
          len_d = i_byte[LW-1:0];
          acc_d = acc_q + i_byte;
          if (i_byte > 8'(MAX_PAYLOAD)) begin
            len_err_d = 1'b1;
            state_d   = S_HUNT;
          end else if (i_byte == 8'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        // SYNC_BYTE here is ordinary data: the length field alone delimits the payload.
        if (i_byte_valid) begin
          payload_d[8*idx_q +: 8] = i_byte;
          acc_d = acc_q + i_byte;
          idx_d = idx_q + 1'b1;
          if (idx_q == len_q - 1'b1) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (i_byte_valid) begin
          if (i_byte == acc_q) begin
            pkt_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            chk_err_d = 1'b1;
            state_d   = S_HUNT;
          end
        end
      end
      S_HOLD: begin
        if (i_pkt_ready) begin
          // The handshake cycle already behaves as hunting, so a SYNC here is not lost.
          pkt_valid_d = 1'b0;
          state_d     = S_HUNT;
          hunt_in     = 1'b1;
        end else if (i_byte_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = S_HUNT;
    endcase

    // Inter-byte timer; a strobe on the terminal cycle takes priority over the timeout.
    if (in_frame) begin
      if (i_byte_valid) begin
        timer_d = '0;
      end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_d = 1'b1;
        timer_d   = '0;
        state_d   = S_HUNT;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (hunt_in && i_byte_valid && (i_byte == SYNC_BYTE)) begin
      state_d   = S_OPC;
      payload_d = '0;
      acc_d     = '0;
      idx_d     = '0;
      timer_d   = '0;
    end
  end

  assign o_pkt_valid   = pkt_valid_q;
  assign o_pkt_opcode  = opcode_q;
  assign o_pkt_len     = len_q;
  assign o_pkt_payload = payload_q;
  assign o_chk_err     = chk_err_q;
  assign o_len_err     = len_err_q;
  assign o_timeout     = timeout_q;
  assign o_overrun     = overrun_q;
  assign o_busy        = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_packet_rx.sv
module tb_uart_packet_rx;

  localparam int MAXP = 16;
  localparam int TO   = 20;
  localparam int LW   = $clog2(MAXP + 1);

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_byte_valid = 1'b0;
  logic [7:0]        i_byte = 8'h00;
  logic              o_pkt_valid;
  logic              i_pkt_ready = 1'b0;
  logic [7:0]        o_pkt_opcode;
  logic [LW-1:0]     o_pkt_len;
  logic [8*MAXP-1:0] o_pkt_payload;
  logic              o_chk_err, o_len_err, o_timeout, o_overrun, o_busy;

  uart_packet_rx #(.MAX_PAYLOAD(MAXP), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .o_pkt_valid(o_pkt_valid), .i_pkt_ready(i_pkt_ready), .o_pkt_opcode(o_pkt_opcode),
    .o_pkt_len(o_pkt_len), .o_pkt_payload(o_pkt_payload), .o_chk_err(o_chk_err),
    .o_len_err(o_len_err), .o_timeout(o_timeout), .o_overrun(o_overrun), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0]        opc;
    logic [LW-1:0]     len;
    logic [8*MAXP-1:0] pay;
  } pkt_t;

  typedef struct {
    logic [7:0] opc;
    logic [7:0] len;
    logic [7:0] seed;
    logic       corrupt;
    int         exp_pkt;
    int         exp_chk;
    int         exp_len;
  } vec_t;

  pkt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_pkt = 0, n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Scoreboard and pulse counters, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_chk_err) n_chk++;
      if (o_len_err) n_len++;
      if (o_timeout) n_to++;
      if (o_overrun) n_ovr++;
      if (o_chk_err || o_len_err || o_timeout || o_overrun)
        chk("err_onehot", 128'($onehot({o_chk_err, o_len_err, o_timeout, o_overrun})), 128'(1));
      if (o_pkt_valid && i_pkt_ready) begin
        n_pkt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pkt", 128'(1), 128'(0));
        end else begin
          pkt_t e;
          e = exp_q.pop_front();
          chk("pkt_opcode", 128'(o_pkt_opcode), 128'(e.opc));
          chk("pkt_len", 128'(o_pkt_len), 128'(e.len));
          chk("pkt_payload", 128'(o_pkt_payload), 128'(e.pay));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_byte_valid = 1'b1;
    i_byte       = b;
    @(posedge i_clk); #1;
    i_byte_valid = 1'b0;
  endtask

  // Next strobe is sampled exactly TO edges after the previous one: the last legal moment.
  task automatic stall_byte(input logic [7:0] b);
    repeat (TO - 1) @(posedge i_clk);
    #1;
    i_byte_valid = 1'b1;
    i_byte       = b;
    @(posedge i_clk); #1;
    i_byte_valid = 1'b0;
  endtask

  // Builds a frame from a vector; pushes the expected packet when one should appear.
  task automatic run_vec(input vec_t v, input int vi);
    logic [7:0]        acc;
    logic [7:0]        pb;
    logic [8*MAXP-1:0] pay;
    pkt_t              e;
    int                p0, c0, l0, t0;
    p0 = n_pkt; c0 = n_chk; l0 = n_len; t0 = n_to;
    pay = '0;
    acc = v.opc + v.len;
    send_byte(8'hA5);
    send_byte(v.opc);
    send_byte(v.len);
    if (v.exp_len == 0) begin
      for (int k = 0; k < int'(v.len); k++) begin
        pb = v.seed + 8'(k * 8'h11);
        pay[8*k +: 8] = pb;
        acc = acc + pb;
        send_byte(pb);
      end
      if (v.exp_pkt != 0) begin
        e.opc = v.opc;
        e.len = LW'(v.len);
        e.pay = pay;
        exp_q.push_back(e);
      end
      send_byte(v.corrupt ? acc + 8'd1 : acc);
      chk($sformatf("v%0d_valid_latency", vi), 128'(o_pkt_valid), 128'(v.exp_pkt));
      @(posedge i_clk); #1;
      chk($sformatf("v%0d_valid_drop", vi), 128'(o_pkt_valid), 128'(0));
    end
    repeat (3) @(posedge i_clk);
    #1;
    chk($sformatf("v%0d_pkts", vi), 128'(n_pkt - p0), 128'(v.exp_pkt));
    chk($sformatf("v%0d_chk_err", vi), 128'(n_chk - c0), 128'(v.exp_chk));
    chk($sformatf("v%0d_len_err", vi), 128'(n_len - l0), 128'(v.exp_len));
    chk($sformatf("v%0d_timeout", vi), 128'(n_to - t0), 128'(0));
    chk($sformatf("v%0d_busy", vi), 128'(o_busy), 128'(0));
  endtask

  task automatic send_good(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b);
    pkt_t e;
    e.opc = opc;
    e.len = LW'(2);
    e.pay = '0;
    e.pay[15:0] = {b, a};
    exp_q.push_back(e);
    send_byte(8'hA5); send_byte(opc); send_byte(8'h02); send_byte(a); send_byte(b);
    send_byte(opc + 8'h02 + a + b);
  endtask

  vec_t vecs[8];

  initial begin
    int base;
    vecs[0] = '{opc: 8'h10, len: 8'd2,   seed: 8'h11, corrupt: 1'b0, exp_pkt: 1, exp_chk: 0, exp_len: 0};
    vecs[1] = '{opc: 8'h10, len: 8'd2,   seed: 8'h11, corrupt: 1'b1, exp_pkt: 0, exp_chk: 1, exp_len: 0};
    vecs[2] = '{opc: 8'h07, len: 8'd0,   seed: 8'h00, corrupt: 1'b0, exp_pkt: 1, exp_chk: 0, exp_len: 0};
    vecs[3] = '{opc: 8'h01, len: 8'd17,  seed: 8'h00, corrupt: 1'b0, exp_pkt: 0, exp_chk: 0, exp_len: 1};
    vecs[4] = '{opc: 8'h33, len: 8'd16,  seed: 8'hA5, corrupt: 1'b0, exp_pkt: 1, exp_chk: 0, exp_len: 0};
    vecs[5] = '{opc: 8'hFF, len: 8'd1,   seed: 8'hFE, corrupt: 1'b0, exp_pkt: 1, exp_chk: 0, exp_len: 0};
    vecs[6] = '{opc: 8'h20, len: 8'd16,  seed: 8'hF0, corrupt: 1'b1, exp_pkt: 0, exp_chk: 1, exp_len: 0};
    vecs[7] = '{opc: 8'h44, len: 8'd255, seed: 8'h00, corrupt: 1'b0, exp_pkt: 0, exp_chk: 0, exp_len: 1};

    // Reset state
    #12;
    chk("rst_valid", 128'(o_pkt_valid), 128'(0));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_fields", 128'({o_pkt_opcode, o_pkt_len}), 128'(0));
    chk("rst_payload", 128'(o_pkt_payload), 128'(0));
    chk("rst_pulses", 128'({o_chk_err, o_len_err, o_timeout, o_overrun}), 128'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_pkt_ready = 1'b1;

    // Non-sync bytes are ignored while hunting
    send_byte(8'h00);
    send_byte(8'h5A);
    chk("hunt_ignore_busy", 128'(o_busy), 128'(0));

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Timeout after A5 10 with no further bytes
    base = n_to;
    send_byte(8'hA5);
    send_byte(8'h10);
    chk("to_busy_before", 128'(o_busy), 128'(1));
    repeat (TO + 5) @(posedge i_clk);
    #1;
    chk("to_count", 128'(n_to - base), 128'(1));
    chk("to_busy_after", 128'(o_busy), 128'(0));

    // Bytes arriving on the last cycle before timeout keep the frame alive
    base = n_to;
    begin
      pkt_t e;
      e.opc = 8'h10; e.len = LW'(2); e.pay = '0; e.pay[15:0] = 16'h2211;
      exp_q.push_back(e);
    end
    base = n_pkt;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
    stall_byte(8'h22);
    stall_byte(8'h45);
    repeat (2) @(posedge i_clk);
    #1;
    chk("stall_timeout", 128'(n_to), 128'(1));
    chk("stall_pkt", 128'(n_pkt - base), 128'(1));

    // Hold with ready low: three overruns, payload unchanged, then ready together with SYNC
    i_pkt_ready = 1'b0;
    base = n_ovr;
    send_good(8'h5C, 8'h11, 8'h22);
    for (int i = 0; i < 10 && !o_pkt_valid; i++) @(posedge i_clk);
    chk("hold_valid", 128'(o_pkt_valid), 128'(1));
    send_byte(8'h99);
    send_byte(8'hA5);
    send_byte(8'h01);
    @(posedge i_clk); #1;
    chk("ovr_count", 128'(n_ovr - base), 128'(3));
    chk("ovr_valid_held", 128'(o_pkt_valid), 128'(1));
    base = n_pkt;
    i_pkt_ready = 1'b1;
    i_byte_valid = 1'b1;
    i_byte = 8'hA5;
    @(posedge i_clk); #1;
    i_byte_valid = 1'b0;
    chk("hs_sync_valid", 128'(o_pkt_valid), 128'(0));
    chk("hs_sync_busy", 128'(o_busy), 128'(1));
    chk("hs_pkt", 128'(n_pkt - base), 128'(1));
    begin
      pkt_t e;
      e.opc = 8'h10; e.len = LW'(2); e.pay = '0; e.pay[15:0] = 16'h2211;
      exp_q.push_back(e);
    end
    send_byte(8'h10); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h45);
    @(posedge i_clk); #1;
    chk("hs_next_pkt", 128'(n_pkt - base), 128'(2));

    // Reset mid-payload, then reset mid-hold (valid drops without a clock edge)
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h04); send_byte(8'h11);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("rstpay_busy", 128'(o_busy), 128'(0));
    chk("rstpay_payload", 128'(o_pkt_payload), 128'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_pkt_ready = 1'b0;
    send_good(8'h66, 8'h01, 8'h02);
    chk("rsthold_valid_pre", 128'(o_pkt_valid), 128'(1));
    void'(exp_q.pop_back());
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("rsthold_valid", 128'(o_pkt_valid), 128'(0));
    chk("rsthold_fields", 128'({o_pkt_opcode, o_pkt_len, o_busy}), 128'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_pkt_ready = 1'b1;
    base = n_pkt;
    send_good(8'h10, 8'h11, 8'h22);
    repeat (2) @(posedge i_clk);
    #1;
    chk("post_rst_pkt", 128'(n_pkt - base), 128'(1));
    chk("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
